// File: rtl/conv_layer_ctrl.sv
// conv_layer_ctrl: stage sequencer for one convolution layer pass.
// Walks PRELOAD, then for every output row ROW_0..ROW_2 (KERNEL_SIZE cycles
// each), BIAS and LOAD, and finally parks in IDLE. The 3-bit stage code is
// decoded by the weight cache, image buffer and PE array, so its encoding
// is fixed.
module conv_layer_ctrl #(
    parameter int KERNEL_SIZE = 3,
    parameter int IMAGE_SIZE  = 8,
    parameter int ARRAY_SIZE  = 6,
    parameter int CNT_WIDTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    output logic [2:0]           o_current_state,
    output logic [CNT_WIDTH-1:0] o_cycle_cnt,
    output logic [CNT_WIDTH-1:0] o_row_idx,
    output logic                 o_row_done,
    output logic                 o_busy,
    output logic                 o_done
);

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_PRELOAD = 3'd1,
        ST_ROW_0   = 3'd2,
        ST_ROW_1   = 3'd3,
        ST_ROW_2   = 3'd4,
        ST_BIAS    = 3'd5,
        ST_LOAD    = 3'd6,
        ST_IDLE    = 3'd7
    } state_t;

    localparam logic [CNT_WIDTH-1:0] PRE_LAST = CNT_WIDTH'(IMAGE_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0] KER_LAST = CNT_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(ARRAY_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t               state;
    logic [CNT_WIDTH-1:0] cycle_cnt;
    logic [CNT_WIDTH-1:0] row_idx;
    logic                 row_done;
    logic                 busy;
    logic                 done;

    // Stage sequencer; every output is a flop, pulses default low each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INIT;
            cycle_cnt <= '0;
            row_idx   <= '0;
            row_done  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            row_done <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_INIT, ST_IDLE: begin
                    // Start is honoured even in the o_done cycle, so a held
                    // start gives back-to-back runs with a single IDLE cycle.
                    if (i_start) begin
                        state     <= ST_PRELOAD;
                        cycle_cnt <= '0;
                        row_idx   <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_PRELOAD: begin
                    if (cycle_cnt == PRE_LAST) begin
                        state     <= ST_ROW_0;
                        cycle_cnt <= '0;
                        row_idx   <= '0;
                    end else begin
                        cycle_cnt <= cycle_cnt + CNT_ONE;
                    end
                end
                ST_ROW_0, ST_ROW_1, ST_ROW_2: begin
                    if (cycle_cnt == KER_LAST) begin
                        cycle_cnt <= '0;
                        case (state)
                            ST_ROW_0: state <= ST_ROW_1;
                            ST_ROW_1: state <= ST_ROW_2;
                            default:  state <= ST_BIAS;
                        endcase
                    end else begin
                        cycle_cnt <= cycle_cnt + CNT_ONE;
                    end
                end
                ST_BIAS: begin
                    // LOAD always follows BIAS so the weight address wraps to 0
                    state     <= ST_LOAD;
                    cycle_cnt <= '0;
                    row_done  <= 1'b1;
                end
                ST_LOAD: begin
                    cycle_cnt <= '0;
                    if (row_idx == ROW_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state   <= ST_ROW_0;
                        row_idx <= row_idx + CNT_ONE;
                    end
                end
                default: begin
                    state     <= ST_INIT;
                    cycle_cnt <= '0;
                    row_idx   <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign o_current_state = state;
    assign o_cycle_cnt     = cycle_cnt;
    assign o_row_idx       = row_idx;
    assign o_row_done      = row_done;
    assign o_busy          = busy;
    assign o_done          = done;

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Directed bench for conv_layer_ctrl at default parameters (K=3, I=8, A=6).
// Expected per-cycle values come from a closed-form timeline of a run:
// offset k=1..8 PRELOAD, then 11-cycle row slots, IDLE at k=75.
module tb_conv_layer_ctrl;

    logic       clk;
    logic       rst;
    logic       i_start;
    logic [2:0] o_current_state;
    logic [3:0] o_cycle_cnt;
    logic [3:0] o_row_idx;
    logic       o_row_done;
    logic       o_busy;
    logic       o_done;

    int total = 0;
    int bad   = 0;

    conv_layer_ctrl #(
        .KERNEL_SIZE(3),
        .IMAGE_SIZE (8),
        .ARRAY_SIZE (6),
        .CNT_WIDTH  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .o_current_state(o_current_state),
        .o_cycle_cnt    (o_cycle_cnt),
        .o_row_idx      (o_row_idx),
        .o_row_done     (o_row_done),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock; sample/drive 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".state"}, 16'(o_current_state), 16'd0);
        chk({tag, ".cnt"},   16'(o_cycle_cnt),     16'd0);
        chk({tag, ".row"},   16'(o_row_idx),       16'd0);
        chk({tag, ".rdone"}, 16'(o_row_done),      16'd0);
        chk({tag, ".busy"},  16'(o_busy),          16'd0);
        chk({tag, ".done"},  16'(o_done),          16'd0);
    endtask

    // One run: start sampled in the current cycle T, then offsets 1..75 are
    // checked. glitch pulses i_start in PRELOAD, ROW_1 and LOAD; held keeps
    // i_start high throughout (and leaves it high on return).
    task automatic run_full(input string tag, input bit glitch, input bit held);
        int e_state, e_cnt, e_row, e_rd, e_busy, e_done;
        int n_rd, n_busy, n_mid, j, r;
        n_rd = 0; n_busy = 0; n_mid = 0;
        i_start = 1'b1;
        tick();
        for (int k = 1; k <= 75; k++) begin
            i_start = held | (glitch & ((k == 3) | (k == 13) | (k == 19)));
            e_rd = 0; e_done = 0; e_busy = 1; e_cnt = 0; e_row = 0;
            if (k <= 8) begin
                e_state = 1; e_cnt = k - 1;
            end else if (k <= 74) begin
                j = k - 9; e_row = j / 11; r = j % 11;
                if (r < 9) begin
                    e_state = 2 + r / 3; e_cnt = r % 3;
                end else if (r == 9) begin
                    e_state = 5;
                end else begin
                    e_state = 6; e_rd = 1;
                end
            end else begin
                e_state = 7; e_row = 5; e_busy = 0; e_done = 1;
            end
            chk({tag, ".state"}, 16'(o_current_state), 16'(e_state));
            chk({tag, ".cnt"},   16'(o_cycle_cnt),     16'(e_cnt));
            chk({tag, ".row"},   16'(o_row_idx),       16'(e_row));
            chk({tag, ".rdone"}, 16'(o_row_done),      16'(e_rd));
            chk({tag, ".busy"},  16'(o_busy),          16'(e_busy));
            chk({tag, ".done"},  16'(o_done),          16'(e_done));
            if (o_row_done === 1'b1) n_rd++;
            if (o_busy === 1'b1) n_busy++;
            if (o_current_state >= 3'd2 && o_current_state <= 3'd5) n_mid++;
            if (k < 75) tick();
        end
        chk({tag, ".n_row_done"}, 16'(n_rd),   16'd6);
        chk({tag, ".n_busy"},     16'(n_busy), 16'd74);
        chk({tag, ".n_mid"},      16'(n_mid),  16'd60);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        i_start = 1'b0;
        #3;
        chk_reset_vals("por");
        tick();
        tick();
        rst = 1'b0;

        // idle in INIT with no start
        for (int c = 0; c < 20; c++) begin
            tick();
            chk_reset_vals("init_idle");
        end

        // plain run, then two quiet IDLE cycles
        run_full("run1", 1'b0, 1'b0);
        i_start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("idle.state", 16'(o_current_state), 16'd7);
            chk("idle.done",  16'(o_done),          16'd0);
            chk("idle.busy",  16'(o_busy),          16'd0);
        end

        // start pulses while busy are ignored
        run_full("glitch", 1'b1, 1'b0);
        i_start = 1'b0;
        tick();

        // async reset in row 3, ROW_2, count 1 (offset 49)
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (48) tick();
        chk("pre_rst.state", 16'(o_current_state), 16'd4);
        chk("pre_rst.cnt",   16'(o_cycle_cnt),     16'd1);
        chk("pre_rst.row",   16'(o_row_idx),       16'd3);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        #1;
        rst = 1'b0;
        tick();
        chk_reset_vals("post_rst");
        run_full("after_rst", 1'b0, 1'b0);
        i_start = 1'b0;
        tick();

        // start held high: back-to-back runs with a single IDLE cycle
        run_full("b2b_a", 1'b0, 1'b1);
        run_full("b2b_b", 1'b0, 1'b1);
        i_start = 1'b0;
        tick();
        chk("b2b_end.state", 16'(o_current_state), 16'd7);
        chk("b2b_end.done",  16'(o_done),          16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_layer_ctrl.md
Name: conv_layer_ctrl

Overview:
- Stage sequencer for the convolution layer.
- Generates the 3-bit stage code that the weight cache, image buffer and PE array decode; that code drives weight-address stepping and reset.
- Sweeps a KERNEL_SIZE x KERNEL_SIZE kernel, plus a bias cycle, over every output row of one IMAGE_SIZE x IMAGE_SIZE feature map.
- Sits directly upstream of the weight cache; started by the layer top.

Parameters:
KERNEL_SIZE, 3, kernel edge; cycles spent in each ROW_x stage
IMAGE_SIZE, 8, input edge; PRELOAD length in cycles
ARRAY_SIZE, 6, PE columns; output rows = IMAGE_SIZE-KERNEL_SIZE+1 (must equal ARRAY_SIZE)
CNT_WIDTH, 4, width of cycle and row counters

Ports:
clk  input  1  clock, all flops rising edge
rst  input  1  asynchronous, active-high reset
i_start  input  1  start pulse; sampled only in INIT or IDLE
o_current_state  output  3  stage code (registered)
o_cycle_cnt  output  CNT_WIDTH  cycle index within current stage
o_row_idx  output  CNT_WIDTH  current output row, 0..ARRAY_SIZE-1
o_row_done  output  1  one-cycle pulse: a row's weights/bias fully issued
o_busy  output  1  high in every state except INIT/IDLE
o_done  output  1  one-cycle pulse on entry to IDLE

Behaviour:
- Clock and reset: one clock, clk; rst is asynchronous and active-high.
- Stage codes:
  - INIT=0, PRELOAD=1, ROW_0=2, ROW_1=3, ROW_2=4, BIAS=5, LOAD=6, IDLE=7.
  - These values are fixed and shared with downstream decoders.
- Reset values: o_current_state=INIT; all counters 0; o_row_done, o_busy and o_done all 0. Reset mid-run aborts immediately to these values.
- All outputs are registered; no combinational path from i_start.
- Transitions, evaluated each rising edge:
  - INIT: i_start=1 -> PRELOAD, else stay.
  - PRELOAD:
    - Lasts IMAGE_SIZE cycles; o_cycle_cnt counts 0..IMAGE_SIZE-1.
    - At the last count -> ROW_0, with cycle_cnt=0 and row_idx=0.
  - ROW_0 / ROW_1 / ROW_2:
    - Each lasts KERNEL_SIZE cycles, counting 0..KERNEL_SIZE-1.
    - Then advance to the next stage: ROW_0 -> ROW_1 -> ROW_2 -> BIAS.
  - BIAS: 1 cycle -> LOAD.
  - LOAD:
    - 1 cycle; o_row_done=1 during LOAD, with o_row_idx = the row just finished.
    - If row_idx == ARRAY_SIZE-1 -> IDLE. Else -> ROW_0 with row_idx+1.
    - LOAD always follows BIAS so the downstream weight address returns to 0 before the next row or the next run.
  - IDLE:
    - o_done=1 only in the first IDLE cycle.
    - i_start=1 -> PRELOAD with row_idx cleared; else stay.
- o_cycle_cnt clears to 0 on every stage change. It holds 0 in BIAS, LOAD, INIT and IDLE.
- o_busy=1 in states 1..6.
- i_start while busy is ignored; there is no queuing.
- Per-run length: IMAGE_SIZE + ARRAY_SIZE*(3*KERNEL_SIZE+1) + ARRAY_SIZE cycles; 74 cycles at defaults.
- Weight-issuing cycles per row: 3*KERNEL_SIZE+1 = 10. The downstream address therefore steps 0..9 per row.
- i_start sampled in the same cycle as the o_done pulse is honoured: IDLE -> PRELOAD.

Test Plan:
- Reset, then hold i_start=0 for 20 cycles -> o_current_state=0, o_busy=0, all counters 0 throughout.
- Start pulse at cycle T:
  - state=1 from T+1 for 8 cycles.
  - state=2 at T+9..T+11, 3 at T+12..T+14, 4 at T+15..T+17.
  - 5 at T+18, 6 at T+19 with o_row_done=1 and o_row_idx=0, then 2 at T+20.
- Full run:
  - Exactly 6 o_row_done pulses with o_row_idx 0..5.
  - o_done pulse at T+75; o_busy high for exactly 74 cycles.
  - Count of cycles in states 2..5 = 60.
- i_start pulses in PRELOAD, in ROW_1 and in LOAD -> no effect; run timing is identical to the previous scenario.
- rst asserted asynchronously mid-ROW_2 of row 3 -> outputs return to reset values without a clock edge. A new start then runs a full 74-cycle sequence from row 0.
- i_start held high continuously -> back-to-back runs. IDLE lasts exactly 1 cycle with o_done=1, PRELOAD follows, and the second run's row_idx restarts at 0.
